// File: rtl/transaction_unit.sv
// transaction_unit: executes one inquiry/withdraw/deposit per request for the
// authenticated card, enforcing per-session op-count and withdrawal limits.
module transaction_unit #(
   parameter int balance_width  = 20,
   parameter int max_ops        = 3,
   parameter int withdraw_limit = 10000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     psw_en,
   input  logic                     card_out,
   input  logic [balance_width-1:0] balance,
   input  logic                     op_start,
   input  logic [1:0]               op_sel,
   input  logic [balance_width-1:0] amount,
   output logic [balance_width-1:0] updated_balance,
   output logic                     op_done,
   output logic [balance_width-1:0] disp_balance,
   output logic                     err,
   output logic [1:0]               err_code,
   output logic                     busy
);

   localparam int cnt_w = $clog2(max_ops + 1);
   localparam int sum_w = balance_width + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READY = 2'd1;
   localparam logic [1:0] EXEC  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [1:0] OP_INQ = 2'b00;
   localparam logic [1:0] OP_WD  = 2'b01;
   localparam logic [1:0] OP_DEP = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   localparam logic [1:0] ERR_NONE  = 2'b00;
   localparam logic [1:0] ERR_FUNDS = 2'b01;
   localparam logic [1:0] ERR_LIMIT = 2'b10;
   localparam logic [1:0] ERR_ILL   = 2'b11;

   localparam logic [cnt_w-1:0] max_ops_c  = cnt_w'(max_ops);
   localparam logic [sum_w-1:0] wd_limit_c = sum_w'(withdraw_limit);

   logic [1:0]               state_r;
   logic [1:0]               op_sel_r;
   logic [balance_width-1:0] amount_r;
   logic [balance_width-1:0] bal_r;
   logic [cnt_w-1:0]         ops_cnt_r;
   logic [balance_width-1:0] wd_total_r;
   logic [balance_width-1:0] res_bal_r;
   logic [1:0]               res_code_r;

   logic                     abort_s;
   logic [sum_w-1:0]         wd_sum_s;
   logic [sum_w-1:0]         dep_sum_s;
   logic [balance_width-1:0] nxt_bal_s;
   logic [1:0]               nxt_code_s;

   assign abort_s = ~psw_en | card_out;

   // Evaluate the latched request: prioritised error checks, then the result balance.
   always_comb begin
      wd_sum_s   = {1'b0, wd_total_r} + {1'b0, amount_r};
      dep_sum_s  = {1'b0, bal_r} + {1'b0, amount_r};
      nxt_bal_s  = bal_r;
      nxt_code_s = ERR_NONE;
      if (op_sel_r == OP_ILL) begin
         nxt_code_s = ERR_ILL;
      end else if (ops_cnt_r == max_ops_c) begin
         nxt_code_s = ERR_LIMIT;
      end else if ((op_sel_r == OP_WD) && (amount_r > bal_r)) begin
         nxt_code_s = ERR_FUNDS;
      end else if ((op_sel_r == OP_WD) && (wd_sum_s > wd_limit_c)) begin
         nxt_code_s = ERR_LIMIT;
      end else if ((op_sel_r == OP_DEP) && dep_sum_s[balance_width]) begin
         nxt_code_s = ERR_ILL;
      end else begin
         case (op_sel_r)
            OP_INQ:  nxt_bal_s = bal_r;
            OP_WD:   nxt_bal_s = bal_r - amount_r;
            OP_DEP:  nxt_bal_s = dep_sum_s[balance_width-1:0];
            default: nxt_bal_s = bal_r;
         endcase
      end
   end

   // Session FSM; results are staged in EXEC and published on the DONE edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r         <= IDLE;
         op_sel_r        <= 2'b00;
         amount_r        <= {balance_width{1'b0}};
         bal_r           <= {balance_width{1'b0}};
         ops_cnt_r       <= {cnt_w{1'b0}};
         wd_total_r      <= {balance_width{1'b0}};
         res_bal_r       <= {balance_width{1'b0}};
         res_code_r      <= ERR_NONE;
         updated_balance <= {balance_width{1'b0}};
         disp_balance    <= {balance_width{1'b0}};
         op_done         <= 1'b0;
         err             <= 1'b0;
         err_code        <= ERR_NONE;
         busy            <= 1'b0;
      end else begin
         op_done <= 1'b0;
         case (state_r)
            IDLE: begin
               busy <= 1'b0;
               if (!abort_s) begin
                  state_r    <= READY;
                  ops_cnt_r  <= {cnt_w{1'b0}};
                  wd_total_r <= {balance_width{1'b0}};
               end
            end
            READY: begin
               if (abort_s) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else if (op_start) begin
                  state_r  <= EXEC;
                  busy     <= 1'b1;
                  op_sel_r <= op_sel;
                  amount_r <= amount;
                  bal_r    <= balance;
               end else begin
                  busy <= 1'b0;
               end
            end
            EXEC: begin
               if (abort_s) begin
                  // operation is discarded: nothing staged, counters untouched
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  state_r    <= DONE;
                  busy       <= 1'b1;
                  res_bal_r  <= nxt_bal_s;
                  res_code_r <= nxt_code_s;
                  if (nxt_code_s == ERR_NONE) begin
                     ops_cnt_r <= ops_cnt_r + cnt_w'(1'b1);
                     if (op_sel_r == OP_WD) begin
                        wd_total_r <= wd_sum_s[balance_width-1:0];
                     end
                  end
               end
            end
            DONE: begin
               op_done         <= 1'b1;
               updated_balance <= res_bal_r;
               disp_balance    <= res_bal_r;
               err             <= (res_code_r != ERR_NONE);
               err_code        <= res_code_r;
               busy            <= 1'b0;
               state_r         <= abort_s ? IDLE : READY;
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_transaction_unit.sv
// Scoreboard bench for transaction_unit: a reference model pushes expected
// results when a request is driven; each scenario pops and compares on op_done.
module tb_transaction_unit;

   localparam int bw = 20;

   logic          clk;
   logic          rst;
   logic          psw_en;
   logic          card_out;
   logic [bw-1:0] balance;
   logic          op_start;
   logic [1:0]    op_sel;
   logic [bw-1:0] amount;
   logic [bw-1:0] updated_balance;
   logic          op_done;
   logic [bw-1:0] disp_balance;
   logic          err;
   logic [1:0]    err_code;
   logic          busy;

   typedef struct packed {
      logic [bw-1:0] bal;
      logic [bw-1:0] disp;
      logic          err;
      logic [1:0]    code;
   } res_t;

   res_t   exp_q[$];
   int     checks = 0;
   int     passes = 0;
   int     m_ops  = 0;
   longint m_wd   = 0;

   transaction_unit #(.balance_width(bw), .max_ops(3), .withdraw_limit(10000)) dut (
      .clk(clk), .rst(rst), .psw_en(psw_en), .card_out(card_out), .balance(balance),
      .op_start(op_start), .op_sel(op_sel), .amount(amount),
      .updated_balance(updated_balance), .op_done(op_done), .disp_balance(disp_balance),
      .err(err), .err_code(err_code), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model of one operation; updates the bench's session counters.
   function automatic res_t model(input logic [1:0] sel, input logic [bw-1:0] amt,
                                  input logic [bw-1:0] bal);
      res_t e;
      e.err  = 1'b1;
      e.bal  = bal;
      e.code = 2'b00;
      if (sel == 2'b11) e.code = 2'b11;
      else if (m_ops >= 3) e.code = 2'b10;
      else if (sel == 2'b01 && longint'(amt) > longint'(bal)) e.code = 2'b01;
      else if (sel == 2'b01 && m_wd + longint'(amt) > 64'd10000) e.code = 2'b10;
      else if (sel == 2'b10 && longint'(bal) + longint'(amt) > 64'd1048575) e.code = 2'b11;
      else begin
         e.err = 1'b0;
         m_ops++;
         if (sel == 2'b01) begin
            m_wd += longint'(amt);
            e.bal = bw'(longint'(bal) - longint'(amt));
         end else if (sel == 2'b10) begin
            e.bal = bw'(longint'(bal) + longint'(amt));
         end
      end
      e.disp = e.bal;
      return e;
   endfunction

   // Drive one request, scramble inputs after sampling, wait (bounded) for op_done.
   task automatic run_op(input logic [1:0] sel, input logic [bw-1:0] amt,
                         input logic [bw-1:0] bal, output res_t got, output int lat);
      exp_q.push_back(model(sel, amt, bal));
      op_sel = sel; amount = amt; balance = bal; op_start = 1'b1;
      @(posedge clk); #1;
      op_start = 1'b0; balance = ~bal; amount = ~amt; op_sel = 2'b11;
      lat = -1;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (op_done === 1'b1) begin
            lat = k;
            break;
         end
      end
      got = {updated_balance, disp_balance, err, err_code};
   endtask

   task automatic new_session();
      psw_en = 1'b0;
      @(posedge clk); #1;
      psw_en = 1'b1;
      @(posedge clk); #1;
      m_ops = 0;
      m_wd  = 0;
   endtask

   task automatic test_reset();
      rst = 1'b0; psw_en = 1'b0; card_out = 1'b0; op_start = 1'b0;
      op_sel = 2'b00; amount = '0; balance = '0;
      repeat (2) @(posedge clk);
      #1 checks++;
      if ({updated_balance, disp_balance, op_done, err, err_code, busy} !== '0)
         $display("FAIL reset: got ub=%h db=%h done=%b err=%b code=%b busy=%b, expected all zero",
                  updated_balance, disp_balance, op_done, err, err_code, busy);
      else passes++;
      rst = 1'b1; psw_en = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_withdraw();
      res_t got, e; int lat;
      run_op(2'b01, 20'd100, 20'd500, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e) $display("FAIL wd100: got %h lat %0d, expected %h lat 2", got, lat, e);
      else passes++;
      checks++;
      if (updated_balance !== 20'd400 || disp_balance !== 20'd400 || err !== 1'b0)
         $display("FAIL wd100_const: got ub=%0d db=%0d err=%b, expected 400 400 0", updated_balance, disp_balance, err);
      else passes++;
      run_op(2'b01, 20'd600, 20'd500, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || got.code !== 2'b01) $display("FAIL wd600: got %h lat %0d, expected %h lat 2", got, lat, e);
      else passes++;
      checks++;
      if (dut.ops_cnt_r !== 2'(m_ops)) $display("FAIL ops_unchanged: got %0d, expected %0d", dut.ops_cnt_r, m_ops);
      else passes++;
   endtask

   task automatic test_deposit();
      res_t got, e; int lat;
      new_session();
      run_op(2'b10, 20'h00020, 20'hFFFF0, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || got.code !== 2'b11) $display("FAIL dep_ovf: got %h lat %0d, expected %h", got, lat, e);
      else passes++;
      run_op(2'b10, 20'h0000F, 20'hFFFF0, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || got.bal !== 20'hFFFFF) $display("FAIL dep_max: got %h lat %0d, expected %h", got, lat, e);
      else passes++;
   endtask

   task automatic test_limits();
      res_t got, e; int lat;
      logic [1:0]    sels [5] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
      logic [bw-1:0] amts [5] = '{20'd6000, 20'd5000, 20'd0, 20'd0, 20'd0};
      logic [bw-1:0] bals [5] = '{20'd20000, 20'd14000, 20'd14000, 20'd14000, 20'd14000};
      logic [1:0]    codes[5] = '{2'b00, 2'b10, 2'b00, 2'b00, 2'b10};
      new_session();
      for (int i = 0; i < 5; i++) begin
         run_op(sels[i], amts[i], bals[i], got, lat);
         e = exp_q.pop_front(); checks++;
         if (lat !== 2 || got !== e || got.code !== codes[i])
            $display("FAIL limit_op%0d: got %h lat %0d, expected %h code %b", i, got, lat, e, codes[i]);
         else passes++;
      end
   endtask

   task automatic test_abort();
      res_t got, e; int lat; int n_done;
      logic [bw-1:0] prev;
      prev = updated_balance;
      op_sel = 2'b01; amount = 20'd9000; balance = 20'd20000; op_start = 1'b1;
      @(posedge clk); #1;
      op_start = 1'b0; card_out = 1'b1;
      checks++;
      if (busy !== 1'b1) $display("FAIL busy_exec: got %b, expected 1", busy);
      else passes++;
      @(posedge clk); #1;
      checks++;
      if (busy !== 1'b0 || dut.state_r !== 2'd0) $display("FAIL abort_idle: got busy=%b state=%0d, expected 0 0", busy, dut.state_r);
      else passes++;
      n_done = (op_done === 1'b1) ? 1 : 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (op_done === 1'b1) n_done++;
      end
      checks++;
      if (n_done !== 0 || updated_balance !== prev)
         $display("FAIL abort_discard: got done=%0d ub=%0d, expected 0 %0d", n_done, updated_balance, prev);
      else passes++;
      card_out = 1'b0;
      @(posedge clk); #1;
      m_ops = 0; m_wd = 0;
      run_op(2'b01, 20'd9000, 20'd20000, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || got.err !== 1'b0) $display("FAIL fresh_session: got %h lat %0d, expected %h", got, lat, e);
      else passes++;
   endtask

   task automatic test_illegal_and_ignore();
      res_t got, e; int lat; int n_done;
      new_session();
      run_op(2'b11, 20'd5, 20'd1000, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || got.code !== 2'b11) $display("FAIL illegal: got %h lat %0d, expected %h", got, lat, e);
      else passes++;
      exp_q.push_back(model(2'b01, 20'd50, 20'd1000));
      op_sel = 2'b01; amount = 20'd50; balance = 20'd1000; op_start = 1'b1;
      n_done = 0; got = '0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (k == 2) op_start = 1'b0;
         if (op_done === 1'b1) begin
            n_done++;
            got = {updated_balance, disp_balance, err, err_code};
         end
      end
      e = exp_q.pop_front(); checks++;
      if (n_done !== 1 || got !== e) $display("FAIL ignore_busy: got %0d pulses %h, expected 1 pulse %h", n_done, got, e);
      else passes++;
   endtask

   task automatic test_zero_amount();
      res_t got, e; int lat;
      new_session();
      run_op(2'b01, 20'd0, 20'd777, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || got.bal !== 20'd777) $display("FAIL zero_wd: got %h lat %0d, expected %h", got, lat, e);
      else passes++;
      run_op(2'b10, 20'd0, 20'd777, got, lat);
      e = exp_q.pop_front(); checks++;
      if (lat !== 2 || got !== e || dut.ops_cnt_r !== 2'd2)
         $display("FAIL zero_dep: got %h lat %0d ops %0d, expected %h ops 2", got, lat, dut.ops_cnt_r, e);
      else passes++;
   endtask

   task automatic test_reset_midop();
      op_sel = 2'b10; amount = 20'd10; balance = 20'd100; op_start = 1'b1;
      @(posedge clk); #1;
      op_start = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      #1 checks++;
      if (busy !== 1'b0 || op_done !== 1'b0 || updated_balance !== '0 || dut.state_r !== 2'd0)
         $display("FAIL reset_midop: got busy=%b done=%b ub=%h state=%0d, expected 0 0 0 0",
                  busy, op_done, updated_balance, dut.state_r);
      else passes++;
      repeat (2) @(posedge clk);
      #1 checks++;
      if (op_done !== 1'b0 || exp_q.size() !== 0) $display("FAIL reset_drop: got done=%b q=%0d, expected 0 0", op_done, exp_q.size());
      else passes++;
   endtask

   initial begin
      test_reset();
      test_withdraw();
      test_deposit();
      test_limits();
      test_abort();
      test_illegal_and_ignore();
      test_zero_amount();
      test_reset_midop();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by 200000 ns, expected finish");
      $fatal(1, "timeout");
   end

endmodule
